// File: rtl/autorange_ctrl.sv
// autorange_ctrl: measurement scheduler and AFE range controller.
// Requests conversions from the dual-slope FSM, publishes each result tagged
// with its range, and steps the range (auto, with hysteresis) or applies a
// clamped user range (manual). Every range change is followed by a settle delay.
module autorange_ctrl #(
  parameter int unsigned          NUM_RANGES    = 5,
  parameter int unsigned          COUNT_W       = 16,
  parameter logic [COUNT_W-1:0]   UP_THRESH     = 16'd60000,
  parameter logic [COUNT_W-1:0]   DOWN_THRESH   = 16'd5000,
  parameter int unsigned          HYST_N        = 2,
  parameter int unsigned          SETTLE_CYCLES = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               auto_i,
  input  logic [2:0]         manual_range_i,
  input  logic               conv_busy_i,
  input  logic               conv_valid_i,
  input  logic [COUNT_W-1:0] conv_count_i,
  input  logic               conv_err_i,
  output logic               conv_start_o,
  output logic [2:0]         range_sel_o,
  output logic               result_valid_o,
  output logic [COUNT_W-1:0] result_count_o,
  output logic [2:0]         result_range_o,
  output logic               overrange_o
);

  localparam logic [2:0]       MAX_R       = 3'(NUM_RANGES - 1);
  localparam logic [3:0]       HYST_L      = 4'(HYST_N);
  localparam int unsigned      SET_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_START,
    S_WAIT,
    S_EVAL
  } state_t;

  state_t             state_q;
  logic [2:0]         range_q;
  logic [SET_W-1:0]   settle_q;
  logic [3:0]         up_q;
  logic [3:0]         dn_q;
  logic               err_q;
  logic               auto_q;
  logic               start_q;
  logic               rvalid_q;
  logic [COUNT_W-1:0] rcount_q;
  logic [2:0]         rrange_q;
  logic               ovr_q;

  logic [2:0] target;
  logic [3:0] up_base;
  logic [3:0] dn_base;
  logic [3:0] up_inc;
  logic [3:0] dn_inc;
  logic       is_high;
  logic       is_low;

  // Range target, mode-switch-cleared hysteresis counts and result classification.
  always_comb begin
    target  = auto_i ? range_q : ((manual_range_i > MAX_R) ? MAX_R : manual_range_i);
    up_base = (auto_i != auto_q) ? '0 : up_q;
    dn_base = (auto_i != auto_q) ? '0 : dn_q;
    up_inc  = (up_base == '1) ? up_base : up_base + 4'd1;
    dn_inc  = (dn_base == '1) ? dn_base : dn_base + 4'd1;
    is_high = (rcount_q >= UP_THRESH);
    is_low  = (rcount_q < DOWN_THRESH);
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      range_q  <= MAX_R;
      settle_q <= '0;
      up_q     <= '0;
      dn_q     <= '0;
      err_q    <= 1'b0;
      auto_q   <= 1'b0;
      start_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rcount_q <= '0;
      rrange_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      start_q  <= 1'b0;
      rvalid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (en_i) begin
            range_q  <= target;
            auto_q   <= auto_i;
            settle_q <= SETTLE_LOAD;
            state_q  <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (!en_i) begin
            up_q    <= '0;
            dn_q    <= '0;
            state_q <= S_IDLE;
          end else begin
            settle_q <= settle_q - 1'b1;
            if (settle_q == SETTLE_LAST) state_q <= S_START;
          end
        end

        S_START: begin
          if (!en_i) begin
            up_q    <= '0;
            dn_q    <= '0;
            state_q <= S_IDLE;
          end else if (!conv_busy_i) begin
            start_q <= 1'b1;
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (!en_i) begin
            up_q    <= '0;
            dn_q    <= '0;
            state_q <= S_IDLE;
          end else if (conv_err_i) begin
            err_q   <= 1'b1;
            state_q <= S_EVAL;
          end else if (conv_valid_i) begin
            err_q    <= 1'b0;
            rcount_q <= conv_count_i;
            rrange_q <= range_q;
            ovr_q    <= (conv_count_i >= UP_THRESH) && (range_q == MAX_R);
            rvalid_q <= 1'b1;
            state_q  <= S_EVAL;
          end
        end

        S_EVAL: begin
          if (!en_i) begin
            up_q    <= '0;
            dn_q    <= '0;
            state_q <= S_IDLE;
          end else begin
            auto_q <= auto_i;
            if (!auto_i) begin
              up_q <= '0;
              dn_q <= '0;
              if (!err_q && (target != range_q)) begin
                range_q  <= target;
                settle_q <= SETTLE_LOAD;
                state_q  <= S_SETTLE;
              end else begin
                state_q <= S_START;
              end
            end else if (err_q) begin
              if (range_q < MAX_R) begin
                range_q  <= range_q + 3'd1;
                up_q     <= '0;
                dn_q     <= '0;
                settle_q <= SETTLE_LOAD;
                state_q  <= S_SETTLE;
              end else begin
                // Saturated on the least sensitive range: publish a full-scale overrange result.
                rvalid_q <= 1'b1;
                rcount_q <= '1;
                rrange_q <= MAX_R;
                ovr_q    <= 1'b1;
                up_q     <= up_base;
                dn_q     <= dn_base;
                state_q  <= S_START;
              end
            end else if (is_high) begin
              dn_q <= '0;
              if ((up_inc >= HYST_L) && (range_q < MAX_R)) begin
                range_q  <= range_q + 3'd1;
                up_q     <= '0;
                settle_q <= SETTLE_LOAD;
                state_q  <= S_SETTLE;
              end else begin
                up_q    <= up_inc;
                state_q <= S_START;
              end
            end else if (is_low) begin
              up_q <= '0;
              if ((dn_inc >= HYST_L) && (range_q > 3'd0)) begin
                range_q  <= range_q - 3'd1;
                dn_q     <= '0;
                settle_q <= SETTLE_LOAD;
                state_q  <= S_SETTLE;
              end else begin
                dn_q    <= dn_inc;
                state_q <= S_START;
              end
            end else begin
              up_q    <= '0;
              dn_q    <= '0;
              state_q <= S_START;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign conv_start_o   = start_q;
  assign range_sel_o    = range_q;
  assign result_valid_o = rvalid_q;
  assign result_count_o = rcount_q;
  assign result_range_o = rrange_q;
  assign overrange_o    = ovr_q;

endmodule
